// File: rtl/ram8_pkg.sv
// Shared constants and types for the eight-word Hack RAM bank.
package ram8_pkg;

   localparam int HACK_WORD_W = 16;
   localparam int RAM8_DEPTH  = 8;
   localparam int RAM8_AW     = 3;

   // Address of the last word; the clear sequencer finishes after writing it.
   localparam logic [RAM8_AW-1:0] RAM8_LAST = 3'(RAM8_DEPTH - 1);

   typedef enum logic {
      IDLE     = 1'b0,
      CLEARING = 1'b1
   } clr_state_e;

endpackage

// File: rtl/dmux8way.sv
// 8-way demultiplexer: routes in_i to the output selected by sel_i, all others 0.
module dmux8way (
   input  logic       in_i,
   input  logic [2:0] sel_i,
   output logic [7:0] out_o
);

   // One-hot routing of the data bit to the selected output.
   always_comb begin
      out_o        = '0;
      out_o[sel_i] = in_i;
   end

endmodule

// File: rtl/ram8_clear_seq.sv
// Clear sequencer for ram8_bank: zeroes one word per cycle, words 0..7.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | bank free for external writes; waits for clear_i
//   CLEARING | writes 0 to word cnt_q each edge; exits after word 7
module ram8_clear_seq
   import ram8_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   output logic               busy_o,
   output logic               clr_we_o,
   output logic [RAM8_AW-1:0] clr_addr_o
);

   clr_state_e         state_q, state_d;
   logic [RAM8_AW-1:0] cnt_q,   cnt_d;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a clear request while already clearing does not restart the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clear_i) begin
               state_d = CLEARING;
               cnt_d   = '0;
            end
         end
         CLEARING: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == RAM8_LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded straight from the registered state, so busy is glitch-free.
   always_comb begin
      busy_o     = (state_q == CLEARING);
      clr_we_o   = (state_q == CLEARING);
      clr_addr_o = cnt_q;
   end

endmodule

// File: rtl/ram8_bank.sv
// Eight-word register bank with combinational read.
// Optional bulk clear sequencer enabled by defining RAM8_CLEAR_EN.
module ram8_bank
   import ram8_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic               load,
   input  logic [RAM8_AW-1:0] address,
`ifdef RAM8_CLEAR_EN
   input  logic               clear,
`endif
   output logic               busy,
   output logic [WIDTH-1:0]   out
);

   logic                    wr_en;
   logic [RAM8_AW-1:0]      wr_addr;
   logic [WIDTH-1:0]        wr_data;
   logic [RAM8_DEPTH-1:0]   word_we;
   logic [WIDTH-1:0]        mem_q [RAM8_DEPTH];

`ifdef RAM8_CLEAR_EN
   logic               clr_we;
   logic [RAM8_AW-1:0] clr_addr;

   ram8_clear_seq u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // Write-port mux: the sequencer owns the port while clearing; a clear
   // request in IDLE drops a coincident external load.
   always_comb begin
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
      end else begin
         wr_en   = load & ~clear;
         wr_addr = address;
         wr_data = in;
      end
   end
`else
   assign busy = 1'b0;

   // Without the sequencer every external load goes straight to the bank.
   always_comb begin
      wr_en   = load;
      wr_addr = address;
      wr_data = in;
   end
`endif

   dmux8way u_wr_dec (
      .in_i  (wr_en),
      .sel_i (wr_addr),
      .out_o (word_we)
   );

   // Word storage; each word loads only when its one-hot enable is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RAM8_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RAM8_DEPTH; i++) begin
            if (word_we[i]) begin
               mem_q[i] <= wr_data;
            end
         end
      end
   end

   assign out = mem_q[address];

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank (clear tests active when RAM8_CLEAR_EN is defined).
module tb_ram8_bank;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic        busy;
   logic [15:0] out;
`ifdef RAM8_CLEAR_EN
   logic        clear;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] model [8];

   ram8_bank dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .load    (load),
      .address (address),
`ifdef RAM8_CLEAR_EN
      .clear   (clear),
`endif
      .busy    (busy),
      .out     (out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      model[a] = d;
   endtask

   task automatic fill_bank();
      for (int k = 0; k < 8; k++) begin
         write_word(3'(k), 16'hC000 + 16'(k * 16'h0101) + 16'h0001);
      end
   endtask

   typedef struct {
      logic        ld;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [16];

   initial begin
      rst     = 1'b1;
      in      = '0;
      load    = 1'b0;
      address = '0;
`ifdef RAM8_CLEAR_EN
      clear   = 1'b0;
`endif
      for (int k = 0; k < 8; k++) model[k] = '0;

      // Reset sweep
      #3;
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         chk($sformatf("reset_out[%0d]", k), out, 16'h0000);
      end
      chk("reset_busy", {15'd0, busy}, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table: write 0x1111*(k+1) to k, then read back all
      for (int k = 0; k < 8; k++) begin
         vt[k]     = '{1'b1, 3'(k), 16'(16'h1111 * (k + 1)), 16'(16'h1111 * (k + 1))};
         vt[k + 8] = '{1'b0, 3'(k), 16'hFFFF,                16'(16'h1111 * (k + 1))};
      end
      for (int i = 0; i < 16; i++) begin
         address = vt[i].a;
         in      = vt[i].d;
         load    = vt[i].ld;
         tick();
         load    = 1'b0;
         if (vt[i].ld) model[vt[i].a] = vt[i].d;
         #1;
         chk($sformatf("vec[%0d]_addr%0d", i, vt[i].a), out, vt[i].exp);
      end

      // Same-address write then read
      address = 3'd3;
      in      = 16'hBEEF;
      load    = 1'b1;
      #1;
      chk("beef_before_edge", out, 16'h4444);
      tick();
      load = 1'b0;
      model[3] = 16'hBEEF;
      chk("beef_after_edge", out, 16'hBEEF);
      address = 3'd2;
      #1;
      chk("beef_neighbour", out, 16'h3333);

      // Randomized traffic against the array model
      for (int i = 0; i < 300; i++) begin
         address = 3'($urandom_range(0, 7));
         in      = 16'($urandom);
         load    = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("rand_read[%0d]", i), out, model[address]);
         tick();
         if (load) model[address] = in;
         load = 1'b0;
         chk($sformatf("rand_busy[%0d]", i), {15'd0, busy}, 16'h0000);
      end
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         chk($sformatf("rand_sweep[%0d]", k), out, model[k]);
      end

`ifdef RAM8_CLEAR_EN
      // Clear: ordered zeroing, 8 busy cycles
      fill_bank();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy_rise", {15'd0, busy}, 16'h0001);
      for (int j = 0; j < 8; j++) begin
         address = 3'(j);
         #1;
         chk($sformatf("clr_before[%0d]", j), out, model[j]);
         if (j < 7) begin
            address = 3'd7;
            #1;
            chk($sformatf("clr_w7_hold[%0d]", j), out, model[7]);
            address = 3'(j);
         end
         tick();
         chk($sformatf("clr_after[%0d]", j), out, 16'h0000);
         chk($sformatf("clr_busy[%0d]", j), {15'd0, busy}, (j < 7) ? 16'h0001 : 16'h0000);
      end
      for (int k = 0; k < 8; k++) model[k] = '0;

      // Load and a repeated clear during busy are both ignored
      fill_bank();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      address = 3'd0;
      in      = 16'hAAAA;
      load    = 1'b1;
      clear   = 1'b1;
      tick();
      load    = 1'b0;
      clear   = 1'b0;
      begin
         int n = 2;
         while (busy && n < 20) begin
            tick();
            n++;
         end
         chk("clr_busy_len", 16'(n), 16'd8);
      end
      address = 3'd0;
      #1;
      chk("clr_load_ignored", out, 16'h0000);
      for (int k = 0; k < 8; k++) model[k] = '0;

      // Clear wins over a coincident load
      fill_bank();
      address = 3'd2;
      in      = 16'h1234;
      load    = 1'b1;
      clear   = 1'b1;
      tick();
      load    = 1'b0;
      clear   = 1'b0;
      chk("cl_busy", {15'd0, busy}, 16'h0001);
      chk("cl_word2_old", out, model[2]);
      for (int j = 0; j < 8; j++) begin
         tick();
         chk($sformatf("cl_not1234[%0d]", j), {15'd0, out == 16'h1234}, 16'h0000);
      end
      chk("cl_word2_end", out, 16'h0000);
      chk("cl_busy_end", {15'd0, busy}, 16'h0000);
      for (int k = 0; k < 8; k++) model[k] = '0;

      // Reset during the 4th busy cycle
      fill_bank();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", {15'd0, busy}, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         chk($sformatf("rst_mid_out[%0d]", k), out, 16'h0000);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      address = 3'd6;
      in      = 16'h00FF;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      chk("rst_then_load", out, 16'h00FF);
      chk("rst_no_busy", {15'd0, busy}, 16'h0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
